// File: rtl/prgmem_loader.sv
// Brainfuck source loader: encodes ASCII commands and writes them into program RAM from address 0.
// Optional bracket balance checking is enabled by defining BRAINHACK_BRACKET_CHECK_EN.
`timescale 1ns/1ps
module prgmem_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [7:0]             i_data,
    input  logic                   i_last,
    output logic                   o_prgmem_in,
    output logic [ADDR_WIDTH-1:0]  o_prgmem_addr,
    output logic [INSTR_WIDTH-1:0] o_prgmem_data,
    output logic                   o_cpu_hold,
    output logic                   o_done,
    output logic                   o_error,
    output logic [ADDR_WIDTH:0]    o_length
);

    typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERROR} state_t;

    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_wr_en;
    logic [ADDR_WIDTH-1:0]    r_wr_addr;
    logic [INSTR_WIDTH-1:0]   r_wr_data;
    logic [ADDR_WIDTH:0]      r_length;

    logic                     w_accept;
    logic                     w_restart;
    logic                     w_is_cmd;
    logic [2:0]               w_code;
    logic                     w_full;
    logic                     w_bracket_err;
    logic                     w_last_err;
    logic                     w_fail;
    logic                     w_write;

    always_comb begin
        w_is_cmd = 1'b1;
        w_code   = 3'd0;
        case (i_data)
            8'h2B:   w_code = 3'd0;  // +
            8'h2D:   w_code = 3'd1;  // -
            8'h3E:   w_code = 3'd2;  // >
            8'h3C:   w_code = 3'd3;  // <
            8'h5B:   w_code = 3'd4;  // [
            8'h5D:   w_code = 3'd5;  // ]
            8'h2E:   w_code = 3'd6;  // .
            8'h2C:   w_code = 3'd7;  // ,
            default: w_is_cmd = 1'b0;
        endcase
    end

    assign w_accept  = i_valid && (r_state == S_LOAD);
    assign w_restart = i_start && (r_state != S_LOAD);
    // Length only ever reaches 2**ADDR_WIDTH, so its top bit alone means "memory full".
    assign w_full    = r_length[ADDR_WIDTH];

`ifdef BRAINHACK_BRACKET_CHECK_EN
    logic [ADDR_WIDTH:0] r_depth;
    logic [ADDR_WIDTH:0] w_depth_after;

    always_comb begin
        w_depth_after = r_depth;
        if (w_is_cmd && w_code == 3'd4)
            w_depth_after = r_depth + LEN_ONE;
        else if (w_is_cmd && w_code == 3'd5 && r_depth != '0)
            w_depth_after = r_depth - LEN_ONE;
    end

    assign w_bracket_err = w_is_cmd && (w_code == 3'd5) && (r_depth == '0);
    assign w_last_err    = i_last && (w_depth_after != '0);

    always_ff @(posedge clock) begin
        if (reset)
            r_depth <= '0;
        else if (w_restart)
            r_depth <= '0;
        else if (w_write)
            r_depth <= w_depth_after;
    end
`else
    assign w_bracket_err = 1'b0;
    assign w_last_err    = 1'b0;
`endif

    assign w_fail  = w_accept && ((w_is_cmd && w_full) || w_bracket_err || w_last_err);
    assign w_write = w_accept && w_is_cmd && !w_full && !w_bracket_err;

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_LOAD;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_fail)
                    w_state_next = S_ERROR;
                else if (w_accept && i_last)
                    w_state_next = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (i_start)
                    w_state_next = S_LOAD;
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    always_comb begin
        o_ready    = (r_state == S_LOAD);
        o_done     = (r_state == S_DONE);
        o_error    = (r_state == S_ERROR);
        o_cpu_hold = (r_state != S_DONE);
    end

    // NOTE: the write address is the current length, so addr and length advance together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_length  <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= r_length[ADDR_WIDTH-1:0];
                r_wr_data <= INSTR_WIDTH'(w_code);
                r_length  <= r_length + LEN_ONE;
            end else if (w_restart) begin
                r_wr_addr <= '0;
                r_length  <= '0;
            end
        end
    end

    assign o_prgmem_in   = r_wr_en;
    assign o_prgmem_addr = r_wr_addr;
    assign o_prgmem_data = r_wr_data;
    assign o_length      = r_length;

endmodule

// File: tb/tb_prgmem_loader.sv
// Self-checking bench for prgmem_loader: directed and random source streams against a string-level model.
`timescale 1ns/1ps
module tb_prgmem_loader;

    localparam int AW    = 3;
    localparam int IW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef BRAINHACK_BRACKET_CHECK_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          i_start;
    logic          i_valid;
    logic          o_ready;
    logic [7:0]    i_data;
    logic          i_last;
    logic          o_prgmem_in;
    logic [AW-1:0] o_prgmem_addr;
    logic [IW-1:0] o_prgmem_data;
    logic          o_cpu_hold;
    logic          o_done;
    logic          o_error;
    logic [AW:0]   o_length;

    prgmem_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_start      (i_start),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_prgmem_in  (o_prgmem_in),
        .o_prgmem_addr(o_prgmem_addr),
        .o_prgmem_data(o_prgmem_data),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_length     (o_length)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] d;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  e_len;
    bit  e_done;
    bit  e_err;

    // Every write pulse the DUT issues, sampled mid-cycle.
    always @(negedge clock) begin
        if (o_prgmem_in === 1'b1) got_q.push_back(wr_t'{a: o_prgmem_addr, d: o_prgmem_data});
    end

    function automatic int enc(input byte c);
        case (c)
            "+": return 0;
            "-": return 1;
            ">": return 2;
            "<": return 3;
            "[": return 4;
            "]": return 5;
            ".": return 6;
            ",": return 7;
            default: return -1;
        endcase
    endfunction

    // Reference: walk the source text, stop at the first error or at the last byte.
    task automatic model(input string s);
        int len   = 0;
        int depth = 0;
        exp_q.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            int code = enc(s[i]);
            if (code >= 0) begin
                if (len == DEPTH) begin e_err = 1'b1; break; end
                if (BR_EN && code == 5 && depth == 0) begin e_err = 1'b1; break; end
                exp_q.push_back(wr_t'{a: AW'(len), d: IW'(code)});
                len++;
                if (code == 4) depth++;
                if (code == 5) depth--;
            end
            if (i == s.len() - 1) begin
                if (BR_EN && depth != 0) e_err = 1'b1;
                else e_done = 1'b1;
            end
        end
        e_len = len;
    endtask

    task automatic send(input byte b, input bit last);
        @(negedge clock);
        i_valid = 1'b1;
        i_data  = b;
        i_last  = last;
    endtask

    task automatic idle();
        @(negedge clock);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_stream(input string name, input string s, input bit gaps);
        model(s);
        @(posedge clock);
        got_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle();
            send(s[i], i == s.len() - 1);
        end
        idle();
        repeat (2) @(negedge clock);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s.writes: got %0d writes, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s.write%0d: got %0d@%0d, expected %0d@%0d", name, i,
                         got_q[i].d, got_q[i].a, exp_q[i].d, exp_q[i].a);
            end
        end
        n_cmp++;
        if (o_length !== (AW+1)'(e_len)) begin
            n_bad++; $display("FAIL %s.length: got %0d, expected %0d", name, o_length, e_len);
        end
        n_cmp++;
        if (o_done !== e_done) begin
            n_bad++; $display("FAIL %s.done: got %b, expected %b", name, o_done, e_done);
        end
        n_cmp++;
        if (o_error !== e_err) begin
            n_bad++; $display("FAIL %s.error: got %b, expected %b", name, o_error, e_err);
        end
        n_cmp++;
        if (o_cpu_hold !== !e_done) begin
            n_bad++; $display("FAIL %s.hold: got %b, expected %b", name, o_cpu_hold, !e_done);
        end
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++; $display("FAIL %s.ready: got %b, expected 0", name, o_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_prgmem_in !== 1'b0) begin n_bad++; $display("FAIL reset.we: got %b, expected 0", o_prgmem_in); end
        n_cmp++; if (o_prgmem_addr !== '0) begin n_bad++; $display("FAIL reset.addr: got %0d, expected 0", o_prgmem_addr); end
        n_cmp++; if (o_prgmem_data !== '0) begin n_bad++; $display("FAIL reset.data: got %0d, expected 0", o_prgmem_data); end
        n_cmp++; if (o_length !== '0) begin n_bad++; $display("FAIL reset.length: got %0d, expected 0", o_length); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset.done: got %b, expected 0", o_done); end
        n_cmp++; if (o_error !== 1'b0) begin n_bad++; $display("FAIL reset.error: got %b, expected 0", o_error); end
        n_cmp++; if (o_cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset.hold: got %b, expected 1", o_cpu_hold); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset.ready: got %b, expected 1", o_ready); end
    endtask

    task automatic test_directed();
        do_reset(); test_stream("basic", "+>[-].", 1'b0);
        do_reset(); test_stream("ignored", "a+ b\n-", 1'b0);
        do_reset(); test_stream("empty", "x", 1'b0);
        do_reset(); test_stream("full", "++++++++", 1'b0);
        do_reset(); test_stream("overflow", "+++++++++", 1'b0);
        do_reset(); test_stream("close_first", "]", 1'b0);
        do_reset(); test_stream("unbalanced", "[[]", 1'b0);
        do_reset(); test_stream("balanced", "[]", 1'b0);
    endtask

    task automatic test_done_hold();
        do_reset();
        test_stream("hold_pre", "+.", 1'b0);
        @(negedge clock);
        i_valid = 1'b1; i_data = "+"; i_last = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL hold.writes: got %0d, expected 2", got_q.size()); end
        n_cmp++; if (o_length !== 4'd2) begin n_bad++; $display("FAIL hold.length: got %0d, expected 2", o_length); end
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL hold.done: got %b, expected 1", o_done); end
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL restart.ready: got %b, expected 1", o_ready); end
        n_cmp++; if (o_length !== '0) begin n_bad++; $display("FAIL restart.length: got %0d, expected 0", o_length); end
        n_cmp++; if (o_prgmem_addr !== '0) begin n_bad++; $display("FAIL restart.addr: got %0d, expected 0", o_prgmem_addr); end
        n_cmp++; if (o_cpu_hold !== 1'b1) begin n_bad++; $display("FAIL restart.hold: got %b, expected 1", o_cpu_hold); end
        @(negedge clock);
        n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL restart.writes: got %0d, expected 2", got_q.size()); end
    endtask

    task automatic test_start_in_load();
        do_reset();
        model("++-");
        @(posedge clock);
        got_q.delete();
        send("+", 1'b0);
        send("+", 1'b0);
        @(negedge clock);
        i_valid = 1'b0; i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        send("-", 1'b1);
        idle();
        repeat (2) @(negedge clock);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL start_load.writes: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (o_length !== (AW+1)'(e_len)) begin n_bad++; $display("FAIL start_load.length: got %0d, expected %0d", o_length, e_len); end
        n_cmp++; if (o_done !== e_done) begin n_bad++; $display("FAIL start_load.done: got %b, expected %b", o_done, e_done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clock);
        got_q.delete();
        send("+", 1'b0);
        send("-", 1'b0);
        send(">", 1'b0);
        @(negedge clock);
        reset = 1'b1; i_valid = 1'b1; i_data = "<";
        @(negedge clock);
        reset = 1'b0; i_valid = 1'b0;
        n_cmp++; if (o_prgmem_in !== 1'b0) begin n_bad++; $display("FAIL reset_mid.we: got %b, expected 0", o_prgmem_in); end
        n_cmp++; if (o_length !== '0) begin n_bad++; $display("FAIL reset_mid.length: got %0d, expected 0", o_length); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid.ready: got %b, expected 1", o_ready); end
        n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL reset_mid.writes: got %0d, expected 3", got_q.size()); end
        n_cmp++;
        if (got_q.size() < 3 || got_q[2] !== wr_t'{a: AW'(2), d: IW'(2)}) begin
            n_bad++; $display("FAIL reset_mid.third: third write missing or not 2@2");
        end
    endtask

    task automatic test_random();
        string alpha = "+-<>[].,a \n";
        do_reset();
        for (int t = 0; t < 25; t++) begin
            string s = "";
            int n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) s = $sformatf("%s%c", s, alpha[$urandom_range(0, alpha.len() - 1)]);
            test_stream($sformatf("rand%0d", t), s, 1'b1);
            @(negedge clock);
            i_start = 1'b1;
            @(negedge clock);
            i_start = 1'b0;
            n_cmp++;
            if (o_ready !== 1'b1 || o_length !== '0) begin
                n_bad++; $display("FAIL rand%0d.restart: got ready=%b length=%0d, expected ready=1 length=0", t, o_ready, o_length);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0;
        test_reset();
        test_directed();
        test_done_hold();
        test_start_in_load();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
